// File: rtl/mac5_dot_sequencer_if.sv
// Bus bundle between the operand fetch logic, the MAC5 dot-product sequencer
// and the MAC5 multiply/add/normalize pipeline.
//   slave  : the sequencer's view (drives handshake, issue and status signals)
//   master : the environment's view (fetch side, datapath result, job control)
interface mac5_dot_sequencer_if #(
  parameter int LEN_W  = 4,
  parameter int DATA_W = 6
);
  // Job control
  logic              start;
  logic [LEN_W-1:0]  len;

  // Operand fetch handshake
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;

  // Datapath control and feedback
  logic              mac_clr;
  logic              mac_en;
  logic [DATA_W-1:0] mac_x;
  logic [DATA_W-1:0] mac_y;
  logic [DATA_W-1:0] mac_res;

  // Status and result
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [7:0]        cycles;

  modport slave (
    input  start, len, in_valid, in_x, in_y, mac_res,
    output in_ready, mac_clr, mac_en, mac_x, mac_y, busy, done, result, cycles
  );

  modport master (
    output start, len, in_valid, in_x, in_y, mac_res,
    input  in_ready, mac_clr, mac_en, mac_x, mac_y, busy, done, result, cycles
  );
endinterface

// File: rtl/mac5_dot_sequencer.sv
// MAC5 dot-product sequencer.
// Runs one dot product of LEN operand pairs through the 6-bit MAC5 datapath:
// clears the accumulator, issues pairs no faster than ISSUE_II cycles apart so
// the accumulator feedback is respected, drains PIPE_LAT cycles of pipeline and
// returns the normalized result together with a one-cycle done pulse.
//
// Optional feature: define MAC5_PERF_CNT_EN to build the 8-bit saturating
// job-cycle counter on the cycles output. Without it, cycles is tied to zero
// and no counter flops exist.
module mac5_dot_sequencer #(
  parameter int LEN_W    = 4,
  parameter int DATA_W   = 6,
  parameter int PIPE_LAT = 3,
  parameter int ISSUE_II = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac5_dot_sequencer_if.slave  bus
);

  // Counter widths: enough bits to hold ISSUE_II-1 and PIPE_LAT-1, never zero.
  localparam int GAP_W  = (ISSUE_II > 1) ? $clog2(ISSUE_II) : 1;
  localparam int DCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [GAP_W-1:0]  GAP_ZERO  = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(ISSUE_II - 1);
  localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(PIPE_LAT - 1);
  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  // FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [LEN_W-1:0]  issued_q,   issued_d;
  logic [GAP_W-1:0]  gap_q,      gap_d;
  logic [DCNT_W-1:0] dcnt_q,     dcnt_d;
  logic [DATA_W-1:0] result_q,   result_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              in_ready_q, in_ready_d;
  logic              mac_clr_q,  mac_clr_d;

  logic              handshake_s;
  logic              last_pair_s;

  // in_ready comes straight from a flop, so the only in_valid -> output path
  // is the issue strobe itself.
  assign handshake_s = bus.in_valid & in_ready_q;
  assign last_pair_s = (issued_q == (len_q - LEN_ONE));

  // Next-state logic for the job FSM and its counters.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    gap_d    = gap_q;
    dcnt_d   = dcnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len != LEN_ZERO) begin
            state_d  = ST_CLEAR;
            len_d    = bus.len;
            issued_d = LEN_ZERO;
          end else begin
            // Empty vector: dot product is zero, datapath untouched.
            state_d  = ST_DONE;
            result_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_ISSUE;
        gap_d   = GAP_ZERO;
      end
      ST_ISSUE: begin
        if (handshake_s) begin
          issued_d = issued_q + LEN_ONE;
          gap_d    = GAP_LOAD;
          if (last_pair_s) begin
            state_d = ST_DRAIN;
            dcnt_d  = DCNT_LOAD;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (gap_q != GAP_ZERO) begin
          gap_d = gap_q - GAP_ONE;
        end else begin
          // Ready and waiting on in_valid; a stall never aborts the job.
          gap_d = GAP_ZERO;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DCNT_ZERO) begin
          // Last pair has reached the normalize stage output.
          result_d = bus.mac_res;
          state_d  = ST_DONE;
        end else begin
          dcnt_d = dcnt_q - DCNT_ONE;
        end
      end
      ST_DONE: begin
        // start is deliberately not sampled here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output flags decoded from the next state so they leave the block registered.
  always_comb begin
    busy_d     = (state_d == ST_CLEAR) || (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d     = (state_d == ST_DONE);
    mac_clr_d  = (state_d == ST_CLEAR);
    in_ready_d = (state_d == ST_ISSUE) && (gap_d == GAP_ZERO);
  end

  // State, counter and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= LEN_ZERO;
      issued_q   <= LEN_ZERO;
      gap_q      <= GAP_ZERO;
      dcnt_q     <= DCNT_ZERO;
      result_q   <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      mac_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      gap_q      <= gap_d;
      dcnt_q     <= dcnt_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      mac_clr_q  <= mac_clr_d;
    end
  end

`ifdef MAC5_PERF_CNT_EN
  logic [7:0] cycles_q, cycles_d;
  logic       perf_run_q, perf_run_d;

  // Job-cycle counter: cleared on entering CLEAR, counts CLEAR..DONE, saturates.
  always_comb begin
    perf_run_d = perf_run_q;
    cycles_d   = cycles_q;
    if ((state_q == ST_IDLE) && (state_d == ST_CLEAR)) begin
      perf_run_d = 1'b1;
      cycles_d   = 8'h00;
    end else if (perf_run_q) begin
      if (state_q == ST_DONE) begin
        perf_run_d = 1'b0;
      end else begin
        perf_run_d = 1'b1;
      end
      if (cycles_q != 8'hFF) begin
        cycles_d = cycles_q + 8'h01;
      end else begin
        cycles_d = cycles_q;
      end
    end else begin
      perf_run_d = 1'b0;
      cycles_d   = cycles_q;
    end
  end

  // Performance counter flops; value holds after DONE until the next CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q   <= 8'h00;
      perf_run_q <= 1'b0;
    end else begin
      cycles_q   <= cycles_d;
      perf_run_q <= perf_run_d;
    end
  end

  assign bus.cycles = cycles_q;
`else
  assign bus.cycles = 8'h00;
`endif

  assign bus.in_ready = in_ready_q;
  assign bus.mac_clr  = mac_clr_q;
  assign bus.mac_en   = handshake_s;
  assign bus.mac_x    = bus.in_x;
  assign bus.mac_y    = bus.in_y;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;

endmodule
